// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: response FSM
// states and the default geometry/starvation limit.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no read response pending
    RESP_F = 2'd1,  // fetch read data arrives this cycle
    RESP_L = 2'd2   // loader read data arrives this cycle
  } state_t;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/imem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous instruction memory.
// The loader/debug port has priority; the core fetch port is protected from
// starvation by a saturating denied-cycle counter, unless the loader holds
// the lock. Grants are combinational; read data comes back one cycle later.
//
// Handshake: a master holds req until it sees gnt in the same cycle; the
// address/write data are taken in that grant cycle. A read grant is answered
// by rvalid exactly one cycle later; rdata is zero whenever rvalid is zero.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic              fetch_rvalid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  input  logic              ldr_lock_i,
  output logic              ldr_gnt_o,
  output logic              ldr_rvalid_o,
  output logic [DATA_W-1:0] ldr_rdata_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic [1:0]        state_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              starved;

  assign starved = (starve_q == STARVE_LIM);

  // Grants are gated by reset so nothing is accepted while reset is held.
  assign fetch_gnt_o = reset_n && fetch_req_i && !ldr_lock_i && (!ldr_req_i || starved);
  assign ldr_gnt_o   = reset_n && ldr_req_i && !fetch_gnt_o;

  // Memory port: winner's access, or keep the chip enabled while read data is returning.
  always_comb begin
    mem_ce_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = addr_q;
    mem_d_o    = '0;
    if (fetch_gnt_o) begin
      mem_ce_o   = 1'b1;
      mem_addr_o = fetch_addr_i;
    end else if (ldr_gnt_o) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = ldr_we_i;
      mem_addr_o = ldr_addr_i;
      mem_d_o    = ldr_wdata_i;
    end else if (state_q != IDLE) begin
      mem_ce_o   = 1'b1;
    end
  end

  // Next-state values: response state from this cycle's read grant, starvation count, last address.
  always_comb begin
    state_d  = IDLE;
    starve_d = starve_q;
    addr_d   = addr_q;
    if (fetch_gnt_o) begin
      state_d = RESP_F;
    end else if (ldr_gnt_o && !ldr_we_i) begin
      state_d = RESP_L;
    end
    if (ldr_lock_i || fetch_gnt_o) begin
      starve_d = '0;
    end else if (fetch_req_i && !starved) begin
      starve_d = starve_q + 1'b1;
    end
    if (fetch_gnt_o || ldr_gnt_o) begin
      addr_d = mem_addr_o;
    end
  end

  // Response FSM, starvation counter and held address; reset drops any pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
    end
  end

  assign fetch_rvalid_o = (state_q == RESP_F);
  assign ldr_rvalid_o   = (state_q == RESP_L);
  assign fetch_rdata_o  = fetch_rvalid_o ? mem_q_i : '0;
  assign ldr_rdata_o    = ldr_rvalid_o ? mem_q_i : '0;
  assign state_o        = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: behavioural memory device plus a reference model
// (shadow memory array, expected-read queue, integer starvation count).
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          fetch_req, ldr_req, ldr_we, ldr_lock;
  logic [AW-1:0] fetch_addr, ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          fetch_gnt, fetch_rvalid, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] fetch_rdata, ldr_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d, mem_q;
  logic [1:0]    state_dbg;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr),
    .ldr_wdata_i(ldr_wdata), .ldr_lock_i(ldr_lock), .ldr_gnt_o(ldr_gnt),
    .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_d_o(mem_d), .mem_q_i(mem_q), .state_o(state_dbg)
  );

  // ---------------- memory device ----------------
  // Synchronous single-port RAM; output is garbage unless the previous cycle was an enabled read.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      ram[mem_addr] <= mem_d;
      mem_q <= $urandom;
    end else if (mem_ce) begin
      mem_q <= ram[mem_addr];
    end else begin
      mem_q <= $urandom;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] exp_q[$];
  int            exp_who_q[$];   // 1 = fetch read, 2 = loader read
  int            starve_m;
  int            tests_run = 0;
  int            tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_who_q.delete();
    starve_m = 0;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_addr = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fetch_gnt"}, fetch_gnt, 0);
    chk({tag, "_ldr_gnt"}, ldr_gnt, 0);
    chk({tag, "_fetch_rvalid"}, fetch_rvalid, 0);
    chk({tag, "_fetch_rdata"}, fetch_rdata, 0);
    chk({tag, "_ldr_rvalid"}, ldr_rvalid, 0);
    chk({tag, "_ldr_rdata"}, ldr_rdata, 0);
    chk({tag, "_mem_ce"}, mem_ce, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_d"}, mem_d, 0);
    chk({tag, "_state"}, state_dbg, IDLE);
  endtask

  // One clock cycle: inputs already driven after the falling edge; check, then advance the model.
  task automatic cycle();
    logic          fg_e, lg_e;
    int            who;
    logic [DW-1:0] d;
    #1;
    fg_e = fetch_req && !ldr_lock && (!ldr_req || starve_m == SMAX);
    lg_e = ldr_req && !fg_e;
    who  = (exp_who_q.size() > 0) ? exp_who_q[0] : 0;
    d    = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("fetch_gnt", fetch_gnt, fg_e);
    chk("ldr_gnt", ldr_gnt, lg_e);
    chk("mem_ce", mem_ce, fg_e || lg_e || (who != 0));
    chk("mem_we", mem_we, lg_e && ldr_we);
    if (fg_e) chk("mem_addr_fetch", mem_addr, fetch_addr);
    else if (lg_e) chk("mem_addr_ldr", mem_addr, ldr_addr);
    if (lg_e && ldr_we) chk("mem_d", mem_d, ldr_wdata);
    chk("fetch_rvalid", fetch_rvalid, who == 1);
    chk("fetch_rdata", fetch_rdata, (who == 1) ? d : '0);
    chk("ldr_rvalid", ldr_rvalid, who == 2);
    chk("ldr_rdata", ldr_rdata, (who == 2) ? d : '0);
    chk("state", state_dbg, (who == 1) ? RESP_F : (who == 2) ? RESP_L : IDLE);
    @(posedge clk);
    exp_q.delete();
    exp_who_q.delete();
    if (fg_e) begin
      exp_q.push_back(ref_mem[fetch_addr]); exp_who_q.push_back(1);
    end else if (lg_e && !ldr_we) begin
      exp_q.push_back(ref_mem[ldr_addr]); exp_who_q.push_back(2);
    end
    if (lg_e && ldr_we) ref_mem[ldr_addr] = ldr_wdata;
    if (ldr_lock || fg_e) starve_m = 0;
    else if (fetch_req && starve_m < SMAX) starve_m++;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] old_val;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    model_reset();
    idle_inputs();

    // Reset with both requests raised: nothing may be granted.
    fetch_req = 1'b1; ldr_req = 1'b1; fetch_addr = 10'h055; ldr_addr = 10'h0AA;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // Fetch-only stream of three consecutive words, then drain.
    for (int a = 0; a < 3; a++) begin
      fetch_req = 1'b1; fetch_addr = AW'(a);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();

    // Contention: loader wins four cycles, then fetch on the fifth, repeating.
    for (int k = 0; k < 15; k++) begin
      fetch_req = 1'b1; fetch_addr = AW'($urandom_range(0, 1023));
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = AW'($urandom_range(0, 1023));
      #1;
      chk("contention_fetch_turn", fetch_gnt, (k % 5) == 4);
      cycle();
    end
    idle_inputs();
    cycle();

    // Lock: loader writes while fetch waits and is never granted.
    for (int k = 0; k < 8; k++) begin
      ldr_lock = 1'b1; fetch_req = 1'b1; fetch_addr = 10'h3FF;
      ldr_req = (k < 3); ldr_we = 1'b1; ldr_addr = 10'h3FF; ldr_wdata = 32'hDEADBEEF;
      #1;
      chk("lock_fetch_blocked", fetch_gnt, 0);
      cycle();
    end
    idle_inputs();
    fetch_req = 1'b1; fetch_addr = 10'h3FF;
    cycle();
    idle_inputs();
    #1;
    chk("lock_readback", fetch_rdata, 32'hDEADBEEF);
    cycle();

    // Read of 0x010 overlapped by a write to the same word: old value returned.
    old_val = ref_mem[10'h010];
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h010;
    cycle();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h010; ldr_wdata = 32'h12345678;
    #1;
    chk("overlap_old_value", ldr_rdata, old_val);
    cycle();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 10'h010;
    cycle();
    idle_inputs();
    #1;
    chk("overlap_new_value", ldr_rdata, 32'h12345678);
    cycle();

    // Randomized traffic over a small address window to provoke overlaps.
    for (int k = 0; k < 400; k++) begin
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = AW'($urandom_range(0, 15));
      ldr_req    = 1'($urandom_range(0, 1));
      ldr_we     = 1'($urandom_range(0, 1));
      ldr_addr   = AW'($urandom_range(0, 15));
      ldr_wdata  = $urandom;
      ldr_lock   = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();

    // Reset straight after a fetch grant: the pending response is dropped.
    fetch_req = 1'b1; fetch_addr = 10'h005;
    #1;
    chk("rst_mid_grant", fetch_gnt, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk_all_zero("rst_mid_held");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_all_zero("rst_mid_release");
    for (int k = 0; k < 3; k++) cycle();
    fetch_req = 1'b1; fetch_addr = 10'h006;
    cycle();
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of all data ports.
REQ-003 Parameter STARVE_MAX, default 4, SHALL set the number of consecutive denied fetch cycles before fetch is forced to win.
REQ-004 clk  input  1  clock; reset_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_req  input  1  core fetch read request, held until granted.
REQ-006 fetch_addr  input  ADDR_W  fetch word address, sampled in the grant cycle.
REQ-007 fetch_gnt  output  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid  output  1  fetch_rdata valid this cycle.
REQ-009 fetch_rdata  output  DATA_W  fetch read data.
REQ-010 ldr_req  input  1  loader/debug request, held until granted.
REQ-011 ldr_we  input  1  loader request is a write (1) or a read (0).
REQ-012 ldr_addr  input  ADDR_W  loader word address.
REQ-013 ldr_wdata  input  DATA_W  loader write data.
REQ-014 ldr_lock  input  1  loader owns the memory exclusively; fetch is blocked.
REQ-015 ldr_gnt, ldr_rvalid  output  1 each  loader grant and read-data valid.
REQ-016 ldr_rdata  output  DATA_W  loader read data.
REQ-017 mem_ce, mem_we  output  1 each  memory chip enable and write enable.
REQ-018 mem_addr, mem_d  output  ADDR_W, DATA_W  memory address and write data.
REQ-019 mem_q  input  DATA_W  memory read data, valid the cycle after a read access, only while mem_ce=1.

Function
REQ-020 Grant SHALL be combinational in the request cycle, with at most one grant per cycle.
REQ-021 Default priority SHALL be loader over fetch.
REQ-022 Starvation counter SHALL increment each cycle fetch_req=1 without fetch_gnt, saturate at STARVE_MAX, and clear on fetch_gnt.
REQ-023 When the counter equals STARVE_MAX and ldr_lock=0, fetch SHALL win over a simultaneous loader request.
REQ-024 While ldr_lock=1, fetch_gnt SHALL be 0 and the starvation counter SHALL be held at 0.
REQ-025 On a grant, mem_ce=1, and mem_addr/mem_we/mem_d SHALL carry the winner's address/write flag/data; fetch grants drive mem_we=0.
REQ-026 FSM states: IDLE (no response pending), RESP_F (fetch read pending), RESP_L (loader read pending).
REQ-027 A read grant SHALL enter RESP_F or RESP_L next cycle; otherwise the FSM SHALL return to IDLE.
REQ-028 A new grant in a RESP state SHALL be allowed, giving back-to-back reads one word per cycle.
REQ-029 In RESP_F or RESP_L, mem_ce SHALL be 1 even with no new grant (mem_we=0, mem_addr holds last value) so that mem_q is not gated.
REQ-030 In RESP_F, fetch_rvalid=1 and fetch_rdata=mem_q; in RESP_L, ldr_rvalid=1 and ldr_rdata=mem_q; read latency SHALL be exactly 1 cycle after grant.
REQ-031 rdata outputs SHALL be 0 when their rvalid is 0.
REQ-032 Loader writes SHALL complete in the grant cycle and produce no rvalid.
REQ-033 A write granted in a response cycle to the address being returned SHALL leave the returned data as the old value.
REQ-034 In IDLE with no grant, mem_ce=0 and mem_we=0.

Reset
REQ-035 On reset_n=0, the FSM SHALL go to IDLE, the starvation counter SHALL go to 0, and all grants, rvalids, rdata, mem_ce and mem_we SHALL be 0; mem_addr and mem_d SHALL be 0.
REQ-036 A pending response at reset assertion SHALL be dropped, with no rvalid after reset release.

Structure
REQ-037 A shared package SHALL hold the FSM state enumeration, the ADDR_W/DATA_W defaults, and the STARVE_MAX default.
REQ-038 Single module, with no sub-module; the starvation counter is inline.

Verification
REQ-039 Fetch-only: fetch_req held with addresses 0x000, 0x001, 0x002 on consecutive cycles -> gnt each cycle; fetch_rvalid one cycle later with the preloaded words, in order.
REQ-040 Contention: both requests held continuously, STARVE_MAX=4 -> loader granted 4 cycles, then fetch granted on the 5th; the pattern repeats.
REQ-041 Lock: ldr_lock=1 with loader writes of 0xDEADBEEF to 0x3FF and fetch_req=1 -> fetch_gnt=0 throughout; after lock release, a fetch of 0x3FF returns 0xDEADBEEF.
REQ-042 Read/write overlap: loader read of 0x010 followed next cycle by a loader write of 0x12345678 to 0x010 -> ldr_rdata returns the old value; a later read returns 0x12345678.
REQ-043 Reset mid-read: reset_n asserted in the cycle after a fetch grant -> no fetch_rvalid, and all outputs are 0 until the next grant.
